// File: rtl/numarator_mod_bcd_pkg.sv
// rtl/numarator_mod_bcd_pkg.sv - shared types, BCD digit constants and elaboration helpers
//
// Contents:
//   state_t      IDLE / CONV controller states
//   BCD_*        digit constants used by the inline counter and the double-dabble converter
//   clog2()      ceiling log2, sizes counters from parameters
//   to_bcd32()   constant-time decimal conversion (up to 8 digits) for wrap preload values
package numarator_mod_bcd_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    localparam logic [3:0] BCD_ZERO      = 4'd0;
    localparam logic [3:0] BCD_NINE      = 4'd9;
    localparam logic [3:0] BCD_ONE       = 4'd1;
    localparam logic [3:0] BCD_ADJ_LIMIT = 4'd5;
    localparam logic [3:0] BCD_ADJ       = 4'd3;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic logic [31:0] to_bcd32(input int value);
        logic [31:0] r;
        int          v;
        r = '0;
        v = value;
        for (int d = 0; d < 8; d++) begin
            r[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/numarator_mod_bcd_bin2bcd_seq.sv
// rtl/numarator_mod_bcd_bin2bcd_seq.sv - sequential double-dabble binary to BCD converter
//
// Ports:
//   clk, reset    rising-edge clock, asynchronous active-low reset
//   start         captures bin and begins a conversion (one shift per following clock)
//   bin           binary value to convert, sampled on start
//   done          high during the clock whose edge performs the last (WIDTH-th) shift
//   bcd           result of that last shift; only meaningful while done is high
module bin2bcd_seq
    import numarator_mod_bcd_pkg::*;
#(
    parameter int WIDTH  = 6,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int             CW   = (clog2(WIDTH + 1) < 1) ? 1 : clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0]    shift_bin;
    logic [4*DIGITS-1:0] acc;
    logic [4*DIGITS-1:0] adj;
    logic [CW-1:0]       cnt;
    logic                active;

    // Add-3 correction on every digit that would overflow past 9 after doubling.
    always_comb begin
        adj = acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc[4*d +: 4] >= BCD_ADJ_LIMIT) begin
                adj[4*d +: 4] = acc[4*d +: 4] + BCD_ADJ;
            end
        end
    end

    // The final shift is presented combinationally so the owner can capture
    // the result on the same edge that completes the WIDTH-th shift.
    assign bcd  = {adj[4*DIGITS-2:0], shift_bin[WIDTH-1]};
    assign done = active && (cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_bin <= '0;
            acc       <= '0;
            cnt       <= '0;
            active    <= 1'b0;
        end else if (start) begin
            shift_bin <= bin;
            acc       <= '0;
            cnt       <= '0;
            active    <= 1'b1;
        end else if (active) begin
            acc       <= bcd;
            shift_bin <= shift_bin << 1;
            cnt       <= cnt + CW'(1);
            if (cnt == LAST) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/numarator_mod_bcd.sv
// rtl/numarator_mod_bcd.sv - modulo-N up/down stopwatch stage with cascade, preload and BCD copy
//
// Ports:
//   clk, reset    rising-edge clock, asynchronous active-low reset
//   en, cin       count enable and cascade enable (both needed to advance)
//   up_down       1 = up, 0 = down
//   load          synchronous preload strobe, value load_val clamped to MODULUS-1
//   iesire        binary count, always < MODULUS
//   bcd           decimal copy of iesire, digit 0 in bits [3:0]
//   cout          one-cycle pulse in the cycle the wrapped value is visible
//   busy          preload BCD conversion in progress (count frozen)
module numarator_mod_bcd
    import numarator_mod_bcd_pkg::*;
#(
    parameter int MODULUS = 60,
    parameter int WIDTH   = 6,
    parameter int DIGITS  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  cin,
    input  logic                  up_down,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    output logic [WIDTH-1:0]      iesire,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  cout,
    output logic                  busy
);

    localparam int                BW        = 4 * DIGITS;
    localparam logic [WIDTH-1:0]  MAX_VAL   = WIDTH'(MODULUS - 1);
    localparam logic [31:0]       MAX_BCD32 = to_bcd32(MODULUS - 1);
    localparam logic [BW-1:0]     MAX_BCD   = MAX_BCD32[BW-1:0];

    state_t           state, state_nxt;
    logic [WIDTH-1:0] iesire_nxt;
    logic [BW-1:0]    bcd_nxt, bcd_inc, bcd_dec;
    logic             cout_nxt, busy_nxt;
    logic             carry, borrow;
    logic [WIDTH-1:0] load_clamped;
    logic             conv_start, conv_done;
    logic [BW-1:0]    conv_bcd;

    assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    assign conv_start   = (state == IDLE) && load;

    bin2bcd_seq #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (conv_start),
        .bin   (load_clamped),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Digit-serial +1 / -1 with decimal carry and borrow ripple.
    always_comb begin
        bcd_inc = bcd;
        bcd_dec = bcd;
        carry   = 1'b1;
        borrow  = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (carry) begin
                if (bcd[4*d +: 4] == BCD_NINE) begin
                    bcd_inc[4*d +: 4] = BCD_ZERO;
                end else begin
                    bcd_inc[4*d +: 4] = bcd[4*d +: 4] + BCD_ONE;
                    carry             = 1'b0;
                end
            end
            if (borrow) begin
                if (bcd[4*d +: 4] == BCD_ZERO) begin
                    bcd_dec[4*d +: 4] = BCD_NINE;
                end else begin
                    bcd_dec[4*d +: 4] = bcd[4*d +: 4] - BCD_ONE;
                    borrow            = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        iesire_nxt = iesire;
        bcd_nxt    = bcd;
        cout_nxt   = 1'b0;
        busy_nxt   = busy;
        case (state)
            IDLE: begin
                if (load) begin
                    iesire_nxt = load_clamped;
                    busy_nxt   = 1'b1;
                    state_nxt  = CONV;
                end else if (en && cin) begin
                    if (up_down) begin
                        if (iesire == MAX_VAL) begin
                            iesire_nxt = '0;
                            bcd_nxt    = '0;
                            cout_nxt   = 1'b1;
                        end else begin
                            iesire_nxt = iesire + WIDTH'(1);
                            bcd_nxt    = bcd_inc;
                        end
                    end else begin
                        if (iesire == '0) begin
                            iesire_nxt = MAX_VAL;
                            bcd_nxt    = MAX_BCD;
                            cout_nxt   = 1'b1;
                        end else begin
                            iesire_nxt = iesire - WIDTH'(1);
                            bcd_nxt    = bcd_dec;
                        end
                    end
                end
            end
            CONV: begin
                // bcd keeps the pre-load value until the converter finishes.
                if (conv_done) begin
                    bcd_nxt   = conv_bcd;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            iesire <= '0;
            bcd    <= '0;
            cout   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_nxt;
            iesire <= iesire_nxt;
            bcd    <= bcd_nxt;
            cout   <= cout_nxt;
            busy   <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_numarator_mod_bcd.sv
// tb/tb_numarator_mod_bcd.sv - scoreboard bench for numarator_mod_bcd (mod-60 stage and mod-24 cascade)
module tb_numarator_mod_bcd;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       en, cin, up_down, load;
    logic [5:0] load_val;
    logic [5:0] iesire;
    logic [7:0] bcd;
    logic       cout, busy;

    logic       c_en;
    logic [4:0] lo_q, hi_q;
    logic [7:0] lo_bcd, hi_bcd;
    logic       lo_cout, hi_cout, lo_busy, hi_busy;

    numarator_mod_bcd #(.MODULUS(60), .WIDTH(6), .DIGITS(2)) dut (
        .clk(clk), .reset(reset), .en(en), .cin(cin), .up_down(up_down),
        .load(load), .load_val(load_val), .iesire(iesire), .bcd(bcd),
        .cout(cout), .busy(busy)
    );

    numarator_mod_bcd #(.MODULUS(24), .WIDTH(5), .DIGITS(2)) dut_lo (
        .clk(clk), .reset(reset), .en(c_en), .cin(1'b1), .up_down(1'b1),
        .load(1'b0), .load_val(5'd0), .iesire(lo_q), .bcd(lo_bcd),
        .cout(lo_cout), .busy(lo_busy)
    );

    numarator_mod_bcd #(.MODULUS(24), .WIDTH(5), .DIGITS(2)) dut_hi (
        .clk(clk), .reset(reset), .en(c_en), .cin(lo_cout), .up_down(1'b1),
        .load(1'b0), .load_val(5'd0), .iesire(hi_q), .bcd(hi_bcd),
        .cout(hi_cout), .busy(hi_busy)
    );

    typedef struct {
        int q;
        int shown;
        bit co;
        bit bsy;
        int lo;
        int hi;
        bit lo_co;
        bit hi_co;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state: plain integers following the counting rules.
    int m_q, m_shown, m_busy_left;
    bit m_cout;
    int c_lo, c_hi;
    bit c_lo_cout, c_hi_cout;

    function automatic logic [31:0] dec2bcd(input int v);
        return 32'((v / 10) * 16 + (v % 10));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q = 0; m_shown = 0; m_busy_left = 0; m_cout = 0;
        c_lo = 0; c_hi = 0; c_lo_cout = 0; c_hi_cout = 0;
    endtask

    task automatic step(input bit e, input bit ci, input bit ud, input bit ld, input int lv, input bit ce);
        exp_t x;
        bit   hi_adv;
        @(negedge clk);
        en = e; cin = ci; up_down = ud; load = ld; load_val = 6'(lv); c_en = ce;

        if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_busy_left == 0) m_shown = m_q;
            m_cout = 0;
        end else if (ld) begin
            m_q = (lv > 59) ? 59 : lv;
            m_busy_left = 6;
            m_cout = 0;
        end else if (e && ci) begin
            if (ud) begin
                m_cout = (m_q == 59);
                m_q = (m_q + 1) % 60;
            end else begin
                m_cout = (m_q == 0);
                m_q = (m_q + 59) % 60;
            end
            m_shown = m_q;
        end else begin
            m_cout = 0;
        end

        hi_adv = ce && c_lo_cout;
        if (ce) begin
            c_lo_cout = (c_lo == 23);
            c_lo = (c_lo + 1) % 24;
        end else begin
            c_lo_cout = 0;
        end
        if (hi_adv) begin
            c_hi_cout = (c_hi == 23);
            c_hi = (c_hi + 1) % 24;
        end else begin
            c_hi_cout = 0;
        end

        x.q = m_q; x.shown = m_shown; x.co = m_cout; x.bsy = (m_busy_left > 0);
        x.lo = c_lo; x.hi = c_hi; x.lo_co = c_lo_cout; x.hi_co = c_hi_cout;
        sb.push_back(x);
    endtask

    // Monitor: compares DUT outputs 1 time unit after each rising edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check("iesire",  32'(iesire),  32'(x.q));
                check("bcd",     32'(bcd),     dec2bcd(x.shown));
                check("cout",    32'(cout),    32'(x.co));
                check("busy",    32'(busy),    32'(x.bsy));
                check("lo_q",    32'(lo_q),    32'(x.lo));
                check("lo_bcd",  32'(lo_bcd),  dec2bcd(x.lo));
                check("lo_cout", 32'(lo_cout), 32'(x.lo_co));
                check("hi_q",    32'(hi_q),    32'(x.hi));
                check("hi_bcd",  32'(hi_bcd),  dec2bcd(x.hi));
                check("hi_cout", 32'(hi_cout), 32'(x.hi_co));
                check("chain_busy", 32'({lo_busy, hi_busy}), 32'(0));
            end
        end
    end

    initial begin
        reset = 1'b0; en = 0; cin = 0; up_down = 0; load = 0; load_val = '0; c_en = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_iesire", 32'(iesire), 32'(0));
        check("reset_bcd",    32'(bcd),    32'(0));
        check("reset_busy",   32'(busy),   32'(0));
        @(negedge clk);
        reset = 1'b1;

        // Count up to 37, then pull reset asynchronously mid-cycle.
        repeat (37) step(1, 1, 1, 0, 0, 1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_iesire", 32'(iesire), 32'(0));
        check("async_bcd",    32'(bcd),    32'(0));
        check("async_cout",   32'(cout),   32'(0));
        check("async_busy",   32'(busy),   32'(0));
        check("async_lo",     32'(lo_q),   32'(0));
        model_reset();
        en = 0; c_en = 0;
        @(negedge clk);
        reset = 1'b1;

        // Up to 59, pause with en=0, then wrap.
        repeat (59) step(1, 1, 1, 0, 0, 1);
        repeat (5)  step(0, 1, 1, 0, 0, 1);
        step(1, 1, 1, 0, 0, 1);
        // Up to 59 again, hold with cin=0, then wrap.
        repeat (59) step(1, 1, 1, 0, 0, 1);
        repeat (5)  step(1, 0, 1, 0, 0, 1);
        step(1, 1, 1, 0, 0, 1);
        // Down from 0: borrow wrap then plain decrement.
        repeat (3) step(1, 1, 0, 0, 0, 1);
        // Load 42; a second load during conversion and enable are ignored.
        step(0, 1, 1, 1, 42, 1);
        step(1, 1, 1, 1, 7, 1);
        repeat (7) step(1, 1, 1, 0, 0, 1);
        // Clamped load together with enable: load wins.
        step(1, 1, 1, 1, 63, 1);
        repeat (8) step(1, 1, 0, 0, 0, 1);

        // Randomised traffic.
        repeat (1500) begin
            step(($urandom_range(3) != 0), ($urandom_range(7) != 0), 1'($urandom_range(1)),
                 ($urandom_range(15) == 0), int'($urandom_range(63)), ($urandom_range(7) != 0));
        end

        repeat (3) @(posedge clk);
        #2;
        check("sb_drained", 32'(sb.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
